// File: rtl/transmission_8.sv
// Registered 8-channel single-wire transmission: an 8:1 mux feeds an active-low
// 1:8 demux over one shared line, with a single output register stage.
module transmission_8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] iData,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    output logic [7:0] oData
);

    logic [2:0] sel;
    logic       line;
    logic [7:0] nextData;

    assign sel  = {A, B, C};
    assign line = iData[sel];

    // 74x138-style decode: only the selected output follows the line, the rest idle high.
    always_comb begin
        nextData = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            if (sel == 3'(k)) begin
                nextData[k] = line;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            oData <= 8'hFF;
        end else begin
            oData <= nextData;
        end
    end

endmodule

// File: tb/tb_transmission_8.sv
// Self-checking bench for transmission_8: directed test-plan cases plus
// randomized traffic compared against an arithmetic reference model.
module tb_transmission_8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] iData = 8'h00;
    logic       A = 1'b0;
    logic       B = 1'b0;
    logic       C = 1'b0;
    logic [7:0] oData;

    int total = 0;
    int bad = 0;

    transmission_8 dut (
        .clk  (clk),
        .rst_n(rst_n),
        .iData(iData),
        .A    (A),
        .B    (B),
        .C    (C),
        .oData(oData)
    );

    always #5 clk = ~clk;

    // Selected bit passes through; every other line is high, so a zero on the
    // selected channel simply subtracts its weight from 0xFF.
    function automatic logic [7:0] refModel(input logic [7:0] d, input logic [2:0] s);
        int bitVal;
        int weight;
        bitVal = (int'(d) >> int'(s)) % 2;
        weight = 1 << int'(s);
        return 8'(255 - (bitVal == 1 ? 0 : weight));
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic [7:0] d, input logic [2:0] s, input string tag);
        @(negedge clk);
        rst_n = r;
        iData = d;
        {A, B, C} = s;
        @(posedge clk);
        #1;
        chk(tag, oData, r ? refModel(d, s) : 8'hFF);
    endtask

    initial begin
        logic [7:0] held;
        logic [7:0] d;
        logic [2:0] s;
        logic r;

        // Reset, then release
        cyc(1'b0, 8'h00, 3'd0, "reset0");
        cyc(1'b0, 8'h00, 3'd0, "reset1");
        chk("resetConst", oData, 8'hFF);
        cyc(1'b1, 8'h00, 3'd0, "release");
        chk("releaseConst", oData, 8'hFE);

        // Sweep with zeros, each select held for 4 cycles
        for (int s0 = 0; s0 < 8; s0++)
            for (int n = 0; n < 4; n++)
                cyc(1'b1, 8'h00, 3'(s0), "sweepZeros");

        // Sweep with ones
        for (int s0 = 0; s0 < 8; s0++) begin
            cyc(1'b1, 8'hFF, 3'(s0), "sweepOnes");
            chk("onesConst", oData, 8'hFF);
        end

        // 0xA5 pattern, then toggle only unselected bits
        for (int s0 = 0; s0 < 8; s0++) begin
            cyc(1'b1, 8'hA5, 3'(s0), "patternA5");
            held = oData;
            for (int n = 0; n < 3; n++) begin
                d = 8'($urandom);
                d[s0] = 1'b0;
                d = d | (8'hA5 & (8'h01 << s0));
                cyc(1'b1, d, 3'(s0), "unselToggle");
                chk("unselHeld", oData, held);
            end
        end
        cyc(1'b1, 8'hA5, 3'd1, "a5sel1");
        chk("a5sel1Const", oData, 8'hFD);
        cyc(1'b1, 8'hA5, 3'd2, "a5sel2");
        chk("a5sel2Const", oData, 8'hFF);

        // Mid-operation reset
        cyc(1'b1, 8'h00, 3'd5, "midPre");
        chk("midPreConst", oData, 8'hDF);
        cyc(1'b0, 8'h00, 3'd5, "midReset");
        chk("midResetConst", oData, 8'hFF);
        cyc(1'b1, 8'h00, 3'd5, "midPost");
        chk("midPostConst", oData, 8'hDF);

        // Latency: select change between edges is invisible until the next edge
        cyc(1'b1, 8'h00, 3'd0, "latPre");
        @(negedge clk);
        {A, B, C} = 3'b111;
        #1;
        chk("latHold", oData, 8'hFE);
        @(posedge clk);
        #1;
        chk("latAfter", oData, 8'h7F);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 300; n++) begin
            d = 8'($urandom);
            s = 3'($urandom_range(0, 7));
            r = ($urandom_range(0, 9) != 0);
            cyc(r, d, s, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
